// File: rtl/stepper_scheduler.sv
// stepper_scheduler
// Sequences the turret stepper motor from direction/step commands. Commands
// land in a single pending register and are taken from IDLE/OFF on the
// following edge. Each move produces full-step coil phases at a fixed rate.
// Absolute position is tracked against symmetric travel limits. A settle
// period ends each move with a move_done pulse. The coils are de-energized
// after a long idle hold.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   cmd_valid  single-cycle command strobe
//   cmd_dir    0 = left (position decreases), 1 = right (position increases)
//   cmd_steps  number of steps requested
//   coils      coil drive pattern, phases A,B,A',B' as bits [3:0]
//   busy       high in STEP and SETTLE
//   position   signed absolute position in steps
//   at_limit   sticky flag: a step was refused at a travel limit
//   move_done  one-cycle pulse when a move completes
module stepper_scheduler #(
    parameter logic [15:0] STEP_DIV      = 16'd50000,
    parameter logic [15:0] SETTLE_CYCLES = 16'd25000,
    parameter logic [23:0] HOLD_CYCLES   = 24'd5000000,
    parameter logic [15:0] POS_LIMIT     = 16'd200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic        cmd_dir,
    input  logic [7:0]  cmd_steps,
    output logic [3:0]  coils,
    output logic        busy,
    output logic [15:0] position,
    output logic        at_limit,
    output logic        move_done
);

    typedef enum logic [1:0] {IDLE, STEP, SETTLE, OFF} state_t;

    localparam logic signed [16:0] LIM_POS = $signed({1'b0, POS_LIMIT});
    localparam logic signed [16:0] LIM_NEG = -LIM_POS;

    state_t      state, state_n;
    logic [1:0]  phase_idx, phase_idx_n;
    logic [15:0] position_n;
    logic        at_limit_n, limit_dir, limit_dir_n;
    logic        move_done_n;
    logic        energized, energized_n;
    logic        pend_valid, pend_valid_n, pend_dir, pend_dir_n;
    logic [7:0]  pend_steps, pend_steps_n;
    logic        dir_q, dir_n;
    logic [7:0]  rem, rem_n;
    logic [15:0] cnt, cnt_n;
    logic [23:0] hold_cnt, hold_n;

    logic        adv_dir, take, advance, last_step, limit_hit;
    logic signed [16:0] pos_try;

    // State register. The pending command is lost on reset along with
    // everything else.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            phase_idx  <= 2'd0;
            position   <= 16'd0;
            at_limit   <= 1'b0;
            limit_dir  <= 1'b0;
            move_done  <= 1'b0;
            energized  <= 1'b0;
            pend_valid <= 1'b0;
            pend_dir   <= 1'b0;
            pend_steps <= 8'd0;
            dir_q      <= 1'b0;
            rem        <= 8'd0;
            cnt        <= 16'd0;
            hold_cnt   <= 24'd0;
        end else begin
            state      <= state_n;
            phase_idx  <= phase_idx_n;
            position   <= position_n;
            at_limit   <= at_limit_n;
            limit_dir  <= limit_dir_n;
            move_done  <= move_done_n;
            energized  <= energized_n;
            pend_valid <= pend_valid_n;
            pend_dir   <= pend_dir_n;
            pend_steps <= pend_steps_n;
            dir_q      <= dir_n;
            rem        <= rem_n;
            cnt        <= cnt_n;
            hold_cnt   <= hold_n;
        end
    end

    // Next-state logic. Every command goes through the pending register, so a
    // strobe at edge E is taken at E+1. On that edge the first advance happens
    // directly. The same path handles SETTLE-final hand-off, overwrite and
    // zero-step commands. The divider and settle timers share one counter
    // because they are never active at the same time.
    always_comb begin
        state_n      = state;
        phase_idx_n  = phase_idx;
        position_n   = position;
        at_limit_n   = at_limit;
        limit_dir_n  = limit_dir;
        move_done_n  = 1'b0;
        energized_n  = energized;
        pend_valid_n = pend_valid;
        pend_dir_n   = pend_dir;
        pend_steps_n = pend_steps;
        dir_n        = dir_q;
        rem_n        = rem;
        cnt_n        = cnt;
        hold_n       = hold_cnt;
        adv_dir      = dir_q;
        take         = 1'b0;
        advance      = 1'b0;
        last_step    = 1'b0;
        limit_hit    = 1'b0;
        pos_try      = 17'sd0;

        case (state)
            IDLE, OFF: begin
                if (pend_valid) begin
                    take        = 1'b1;
                    energized_n = 1'b1;
                    hold_n      = 24'd0;
                    dir_n       = pend_dir;
                    adv_dir     = pend_dir;
                    if (pend_steps == 8'd0) begin
                        move_done_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        advance   = 1'b1;
                        last_step = (pend_steps == 8'd1);
                        rem_n     = pend_steps - 8'd1;
                    end
                end else if (state == IDLE) begin
                    if (hold_cnt == HOLD_CYCLES - 24'd1 && !cmd_valid) begin
                        state_n     = OFF;
                        energized_n = 1'b0;
                        hold_n      = 24'd0;
                    end else begin
                        hold_n = hold_cnt + 24'd1;
                    end
                end
            end
            STEP: begin
                if (cnt == STEP_DIV - 16'd1) begin
                    advance   = 1'b1;
                    last_step = (rem == 8'd1);
                    rem_n     = rem - 8'd1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_CYCLES - 16'd1) begin
                    move_done_n = 1'b1;
                    state_n     = IDLE;
                    hold_n      = 24'd0;
                    cnt_n       = 16'd0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Limit check happens before the advance. The 17-bit sum keeps a
        // +/-1 step from wrapping around the 16-bit position range.
        if (advance) begin
            pos_try   = adv_dir ? ($signed({position[15], position}) + 17'sd1)
                                : ($signed({position[15], position}) - 17'sd1);
            limit_hit = (pos_try > LIM_POS) || (pos_try < LIM_NEG);
            cnt_n     = 16'd0;
            if (limit_hit) begin
                at_limit_n  = 1'b1;
                limit_dir_n = adv_dir;
                rem_n       = 8'd0;
                state_n     = SETTLE;
            end else begin
                phase_idx_n = adv_dir ? phase_idx + 2'd1 : phase_idx - 2'd1;
                position_n  = pos_try[15:0];
                if (at_limit && adv_dir != limit_dir) begin
                    at_limit_n = 1'b0;
                end
                state_n = last_step ? SETTLE : STEP;
            end
        end

        // A new strobe always wins, even on the edge that consumes the old one.
        if (cmd_valid) begin
            pend_valid_n = 1'b1;
            pend_dir_n   = cmd_dir;
            pend_steps_n = cmd_steps;
        end else if (take) begin
            pend_valid_n = 1'b0;
        end
    end

    // Full-step phase table. The coils stay dark until the first command
    // after reset, and after the hold timeout.
    always_comb begin
        case (phase_idx)
            2'd0:    coils = 4'b1100;
            2'd1:    coils = 4'b0110;
            2'd2:    coils = 4'b0011;
            default: coils = 4'b1001;
        endcase
        if (!energized) begin
            coils = 4'b0000;
        end
    end

    assign busy = (state == STEP) || (state == SETTLE);

endmodule

// File: tb/tb_stepper_scheduler.sv
// tb_stepper_scheduler
// Directed bench for stepper_scheduler with small timing parameters
// (STEP_DIV=4, SETTLE_CYCLES=3, HOLD_CYCLES=10, POS_LIMIT=5).
// Inputs change 1ns after a rising edge. Outputs are sampled at the same point.
module tb_stepper_scheduler;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_dir;
    logic [7:0]  cmd_steps;
    logic [3:0]  coils;
    logic        busy;
    logic [15:0] position;
    logic        at_limit;
    logic        move_done;

    int tests_run = 0;
    int failures  = 0;

    stepper_scheduler #(
        .STEP_DIV(16'd4),
        .SETTLE_CYCLES(16'd3),
        .HOLD_CYCLES(24'd10),
        .POS_LIMIT(16'd5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps),
        .coils(coils),
        .busy(busy),
        .position(position),
        .at_limit(at_limit),
        .move_done(move_done)
    );

    // Free-running 100 MHz clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Strobe one command. On return we are just past the sampling edge E.
    task automatic applyStimulus(input logic dir, input logic [7:0] steps);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = steps;
        tick();
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd0;
    endtask

    // Wait a bounded number of cycles for a move_done pulse
    task automatic waitDone(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (move_done) found = 1'b1;
        end
        checkOutput(tag, 16'(found), 16'd1);
    endtask

    // Directed sequence
    initial begin
        logic bad;
        int   pulses;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd0;
        #2;
        checkOutput("rst_coils", 16'(coils), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_pos", position, 16'd0);
        checkOutput("rst_limit", 16'(at_limit), 16'd0);
        checkOutput("rst_done", 16'(move_done), 16'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Right 3 from reset: phases at E+1, E+5, E+9, done at E+12
        applyStimulus(1'b1, 8'd3);
        tick();
        checkOutput("r3_coils1", 16'(coils), 16'b0110);
        checkOutput("r3_busy1", 16'(busy), 16'd1);
        checkOutput("r3_pos1", position, 16'd1);
        repeat (3) tick();
        checkOutput("r3_coils4", 16'(coils), 16'b0110);
        tick();
        checkOutput("r3_coils5", 16'(coils), 16'b0011);
        checkOutput("r3_pos5", position, 16'd2);
        repeat (4) tick();
        checkOutput("r3_coils9", 16'(coils), 16'b1001);
        checkOutput("r3_pos9", position, 16'd3);
        repeat (2) tick();
        checkOutput("r3_busy11", 16'(busy), 16'd1);
        checkOutput("r3_done11", 16'(move_done), 16'd0);
        tick();
        checkOutput("r3_done12", 16'(move_done), 16'd1);
        checkOutput("r3_busy12", 16'(busy), 16'd0);
        tick();
        checkOutput("r3_done13", 16'(move_done), 16'd0);

        // Left 2 from position 3
        applyStimulus(1'b0, 8'd2);
        tick();
        checkOutput("l2_coils1", 16'(coils), 16'b0011);
        checkOutput("l2_pos1", position, 16'd2);
        repeat (4) tick();
        checkOutput("l2_coils5", 16'(coils), 16'b0110);
        waitDone("l2_done", 20);
        checkOutput("l2_pos", position, 16'd1);
        checkOutput("l2_limit", 16'(at_limit), 16'd0);

        // Hold timeout: dark after 10 idle cycles, then wake with one step
        repeat (9) tick();
        checkOutput("hold_coils9", 16'(coils), 16'b0110);
        tick();
        checkOutput("hold_coils10", 16'(coils), 16'b0000);
        applyStimulus(1'b1, 8'd1);
        checkOutput("wake_coilsE", 16'(coils), 16'b0000);
        tick();
        checkOutput("wake_coils", 16'(coils), 16'b0011);
        checkOutput("wake_pos", position, 16'd2);
        waitDone("wake_done", 20);

        // Right 10 from position 2: three steps, then refused at +5
        applyStimulus(1'b1, 8'd10);
        repeat (12) tick();
        checkOutput("lim_pos12", position, 16'd5);
        checkOutput("lim_flag12", 16'(at_limit), 16'd0);
        tick();
        checkOutput("lim_flag13", 16'(at_limit), 16'd1);
        checkOutput("lim_coils13", 16'(coils), 16'b0110);
        checkOutput("lim_pos13", position, 16'd5);
        checkOutput("lim_busy13", 16'(busy), 16'd1);
        repeat (2) tick();
        checkOutput("lim_done15", 16'(move_done), 16'd0);
        tick();
        checkOutput("lim_done16", 16'(move_done), 16'd1);
        applyStimulus(1'b0, 8'd1);
        tick();
        checkOutput("unlim_pos", position, 16'd4);
        checkOutput("unlim_flag", 16'(at_limit), 16'd0);
        checkOutput("unlim_coils", 16'(coils), 16'b1100);
        waitDone("unlim_done", 20);

        // Left 10 from 4: nine steps down to -5, then refused
        applyStimulus(1'b0, 8'd10);
        waitDone("nlim_done", 80);
        checkOutput("nlim_pos", position, 16'hFFFB);
        checkOutput("nlim_flag", 16'(at_limit), 16'd1);
        checkOutput("nlim_coils", 16'(coils), 16'b1001);
        applyStimulus(1'b1, 8'd1);
        tick();
        checkOutput("nunlim_pos", position, 16'hFFFC);
        checkOutput("nunlim_flag", 16'(at_limit), 16'd0);
        waitDone("nunlim_done", 20);

        // Pending overwrite: right 4, strobe left 1 then left 2 mid-move
        applyStimulus(1'b1, 8'd4);
        tick();
        checkOutput("ovr_pos1", position, 16'hFFFD);
        tick();
        applyStimulus(1'b0, 8'd1);
        repeat (2) tick();
        checkOutput("ovr_pos5", position, 16'hFFFE);
        applyStimulus(1'b0, 8'd2);
        waitDone("ovr_done1", 30);
        checkOutput("ovr_posA", position, 16'd0);
        tick();
        checkOutput("ovr_posB1", position, 16'hFFFF);
        checkOutput("ovr_busyB1", 16'(busy), 16'd1);
        waitDone("ovr_done2", 30);
        checkOutput("ovr_posB", position, 16'hFFFE);
        checkOutput("ovr_coilsB", 16'(coils), 16'b0011);
        pulses = 0;
        repeat (6) begin
            tick();
            if (move_done) pulses++;
        end
        checkOutput("ovr_extra_done", 16'(pulses), 16'd0);
        checkOutput("ovr_pos_final", position, 16'hFFFE);

        // Zero-step command: no motion, move_done one cycle after acceptance
        applyStimulus(1'b1, 8'd0);
        tick();
        checkOutput("zero_done", 16'(move_done), 16'd1);
        checkOutput("zero_busy", 16'(busy), 16'd0);
        checkOutput("zero_pos", position, 16'hFFFE);

        // Asynchronous reset mid-STEP with a command pending
        applyStimulus(1'b1, 8'd3);
        repeat (2) tick();
        checkOutput("mid_pos", position, 16'hFFFF);
        applyStimulus(1'b0, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_coils", 16'(coils), 16'd0);
        checkOutput("arst_busy", 16'(busy), 16'd0);
        checkOutput("arst_pos", position, 16'd0);
        checkOutput("arst_limit", 16'(at_limit), 16'd0);
        tick();
        tick();
        reset = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (busy || coils != 4'b0000 || position != 16'd0 || move_done) bad = 1'b1;
        end
        checkOutput("post_rst_quiet", 16'(bad), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/stepper_scheduler.md
Name: stepper_scheduler

Overview:
- Sequences the turret stepper motor from the direction/step commands produced by the mic-comparison stage.
- Accepts one command per `cmd_valid` pulse and holds at most one pending command while a move is in progress.
- Generates full-step coil phases at a fixed step rate, tracks absolute position against symmetric travel limits, and de-energizes the coils after a hold timeout.

Parameters:
- STEP_DIV, 16'd50000, clock cycles between successive coil phase advances (minimum 2)
- SETTLE_CYCLES, 16'd25000, cycles held after the last step before the move is reported done (minimum 1)
- HOLD_CYCLES, 24'd5000000, idle cycles before the coils are de-energized (minimum 1)
- POS_LIMIT, 16'd200, maximum absolute position in steps; valid travel is -POS_LIMIT..+POS_LIMIT

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  single-cycle command strobe (the upstream done pulse)
- cmd_dir  input  1  0 = left (position decreases), 1 = right (position increases)
- cmd_steps  input  8  number of steps requested
- coils  output  4  coil drive pattern, phases A,B,A',B' as bits [3:0]
- busy  output  1  high in STEP and SETTLE states
- position  output  16  signed two's-complement absolute position in steps
- at_limit  output  1  a step was refused at a travel limit (sticky)
- move_done  output  1  one-cycle pulse when a move completes

Behaviour:
- Reset (reset low, asynchronous), all outputs and state cleared:
  - coils=0000, busy=0, position=0, at_limit=0, move_done=0
  - phase index=0, pending register empty, state IDLE, all counters 0.
- Phase table, index 0..3: 1100, 0110, 0011, 1001.
  - A step with dir=1 increments the index mod 4 and position by 1.
  - A step with dir=0 decrements the index mod 4 and position by 1.
- States: IDLE, STEP, SETTLE, OFF.
- IDLE:
  - coils shows the current phase; the hold counter increments each cycle.
  - The hold counter reaching HOLD_CYCLES-1 with no command moves the block to OFF.
- OFF: coils=0000; the phase index is retained.
- Command accept in IDLE or OFF (cmd_valid sampled at edge E):
  - With cmd_steps=0: no motion; move_done pulses at E+1; the state returns to IDLE (hold counter cleared).
  - Otherwise: latch dir/steps and enter STEP.
  - The first phase advance is visible after edge E+1.
  - Each subsequent advance follows exactly STEP_DIV cycles after the previous one.
  - Coming from OFF, coils drive the new phase at E+1 (no separate re-energize cycle).
- STEP:
  - After each advance the remaining count decrements.
  - When the remaining count reaches 0, enter SETTLE on the same edge as the last advance.
- Limit check: before each advance, if the new position would leave -POS_LIMIT..+POS_LIMIT:
  - the step is not taken (coils and position unchanged);
  - the remaining steps are discarded;
  - at_limit is set to 1 and the state enters SETTLE.
- at_limit clears on the first successful step in the opposite direction.
- SETTLE:
  - coils hold; the state lasts SETTLE_CYCLES cycles.
  - On the final cycle, move_done pulses 1 cycle, busy drops, and:
    - if the pending register is full, its command is accepted as if strobed on that edge (the next advance is one cycle later);
    - otherwise the state returns to IDLE with the hold counter cleared.
- cmd_valid while busy: the command is written to the single pending register.
  - A newer command overwrites an older pending one; no command is ever refused.
  - A strobe on the SETTLE-final edge is captured and executed, not lost.
- A pending command with cmd_steps=0 completes as a no-op: move_done pulses one cycle after it is taken.
- Arithmetic widths:
  - position: 16-bit signed.
  - Limit compare: ±1 computed in 17 bits, compared against signed POS_LIMIT; no wrap is possible.
  - step counter: 8 bits.
  - divider/settle counter: 16 bits.
  - hold counter: 24 bits.
- Reset mid-move: immediate return to reset values; the pending command is lost; position returns to 0.

Test Plan:
Bench parameters: STEP_DIV=4, SETTLE_CYCLES=3, HOLD_CYCLES=10, POS_LIMIT=5.
- Right 3 steps from reset (dir=1, steps=3) -> coils 0110, 0011, 1001 at E+1, E+5, E+9; position=3; busy high E+1..E+11; move_done pulse at E+12.
- Left 2 steps from position 3 -> coils 0011, 0110; position=1; at_limit stays 0.
- Right 10 steps from position 0 -> 5 steps taken, position=5, at_limit=1; settle follows the refused step; a later left 1 step -> position=4, at_limit=0.
- Pending overwrite: during a 4-step right move, strobe left 1, then left 2 -> after move_done, exactly 2 left steps execute; two move_done pulses total.
- Idle 10 cycles after move_done -> coils=0000; next right 1 command -> coils show the next phase one cycle later, position +1.
- Assert reset low mid-STEP with a pending command -> outputs 0 immediately (asynchronous); no further motion after release.
